// File: rtl/rsa_seq_ctrl.sv
// Sequencing controller for the RSA core: orders inverter/mod_exp resets,
// holds operands stable per job, and returns the result or a timeout error.
module rsa_seq_ctrl #(
  parameter int WIDTH    = 1024,
  parameter int KEY_WAIT = 4096,
  parameter int TIMEOUT  = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_enc_i,
  input  logic                 req_key_reuse_i,
  input  logic [WIDTH-1:0]     req_p_i,
  input  logic [WIDTH-1:0]     req_q_i,
  input  logic [2*WIDTH-1:0]   req_msg_i,
  input  logic                 abort_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [2*WIDTH-1:0]   resp_data_o,
  output logic                 resp_err_o,
  output logic                 busy_o,
  output logic                 core_rst_n_o,
  output logic                 core_rst1_n_o,
  output logic                 core_enc_o,
  output logic [WIDTH-1:0]     core_p_o,
  output logic [WIDTH-1:0]     core_q_o,
  output logic [2*WIDTH-1:0]   core_msg_o,
  input  logic                 core_finish_i,
  input  logic [2*WIDTH-1:0]   core_msg_i
);

  localparam int MAXC = (KEY_WAIT > TIMEOUT) ? KEY_WAIT : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KEYGEN, S_SETUP, S_EXP, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_key_valid;
  logic                 r_inv_run;
  logic                 r_enc;
  logic                 r_err;
  logic [WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]     r_q;
  logic [2*WIDTH-1:0]   r_msg;
  logic [2*WIDTH-1:0]   r_data;
  logic                 w_accept;
  logic                 w_reuse_ok;

  assign w_accept   = req_valid_i & req_ready_o;
  assign w_reuse_ok = req_key_reuse_i & r_key_valid;

  // State register plus all datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_inv_run   <= 1'b0;
      r_enc       <= 1'b0;
      r_err       <= 1'b0;
      r_p         <= '0;
      r_q         <= '0;
      r_msg       <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_p   <= req_p_i;
        r_q   <= req_q_i;
        r_msg <= req_msg_i;
        r_enc <= req_enc_i;
        if (!w_reuse_ok)
          r_key_valid <= 1'b0;
      end
      if (r_state == S_KEYGEN && w_next == S_SETUP)
        r_key_valid <= 1'b1;

      // Inverter stays released after KEYGEN, even across an abort, until the next LOAD
      if (w_next == S_LOAD)
        r_inv_run <= 1'b0;
      else if (w_next == S_KEYGEN)
        r_inv_run <= 1'b1;

      if (r_state == S_EXP && w_next == S_DONE) begin
        if (core_finish_i) begin
          r_data <= core_msg_i;
          r_err  <= 1'b0;
        end else begin
          r_data <= '0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = w_reuse_ok ? S_SETUP : S_LOAD;
      S_LOAD:
        if (abort_i)                          w_next = S_IDLE;
        else if (r_cnt == CW'(1))             w_next = S_KEYGEN;
      S_KEYGEN:
        if (abort_i)                          w_next = S_IDLE;
        else if (r_cnt == CW'(KEY_WAIT - 1))  w_next = S_SETUP;
      S_SETUP:
        if (abort_i)                          w_next = S_IDLE;
        else if (r_cnt == CW'(1))             w_next = S_EXP;
      // Finish and timeout together resolve as a finish in the datapath capture
      S_EXP:
        if (abort_i)                          w_next = S_IDLE;
        else if (core_finish_i || r_cnt == CW'(TIMEOUT - 1))
                                              w_next = S_DONE;
      S_DONE:
        if (resp_ready_i)                     w_next = S_IDLE;
      default:                                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    busy_o        = 1'b1;
    resp_valid_o  = 1'b0;
    core_rst1_n_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_EXP:  core_rst1_n_o = 1'b1;
      S_DONE: resp_valid_o  = 1'b1;
      default: ;
    endcase
  end

  assign core_rst_n_o = r_inv_run;
  assign core_enc_o   = r_enc;
  assign core_p_o     = r_p;
  assign core_q_o     = r_q;
  assign core_msg_o   = r_msg;
  assign resp_data_o  = r_data;
  assign resp_err_o   = r_err;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Directed bench for rsa_seq_ctrl with a behavioural core model that raises
// finish a set number of cycles after its mod_exp reset is released.
module tb_rsa_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, req_valid_i, req_ready_o, req_enc_i, req_key_reuse_i;
  logic [W-1:0] req_p_i, req_q_i;
  logic [2*W-1:0] req_msg_i, resp_data_o, core_msg_o, core_msg_i;
  logic         abort_i, resp_valid_o, resp_ready_i, resp_err_o, busy_o;
  logic         core_rst_n_o, core_rst1_n_o, core_enc_o, core_finish_i;
  logic [W-1:0] core_p_o, core_q_o;

  int           mdl_n   = -1;
  logic [7:0]   mdl_val = '0;
  int           mdl_cnt = 0;
  logic         fin_force = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  rsa_seq_ctrl #(.WIDTH(W), .KEY_WAIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_enc_i(req_enc_i), .req_key_reuse_i(req_key_reuse_i),
    .req_p_i(req_p_i), .req_q_i(req_q_i), .req_msg_i(req_msg_i),
    .abort_i(abort_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
    .core_rst_n_o(core_rst_n_o), .core_rst1_n_o(core_rst1_n_o),
    .core_enc_o(core_enc_o), .core_p_o(core_p_o), .core_q_o(core_q_o),
    .core_msg_o(core_msg_o), .core_finish_i(core_finish_i),
    .core_msg_i(core_msg_i)
  );

  always #5 clk = ~clk;

  // Core model: cycles since mod_exp reset release
  always @(posedge clk) begin
    if (!core_rst1_n_o) mdl_cnt <= 0;
    else                mdl_cnt <= mdl_cnt + 1;
  end
  assign core_finish_i = fin_force | (core_rst1_n_o && mdl_n >= 0 && mdl_cnt == mdl_n);
  assign core_msg_i    = {8'h00, mdl_val};

  typedef struct {
    string      nm;
    logic [6:0] in7;   // rst_n, req_valid, enc, reuse, abort, resp_ready, force_finish
    logic [7:0] msg;
    int         mn;
    logic [7:0] mv;
    logic [6:0] est;   // req_ready, busy, rst_n, rst1_n, enc, resp_valid, resp_err
    logic [7:0] ed;
    logic [7:0] em;
    logic       epq;
  } vec_t;

  vec_t       tbl[$];
  int         j_n   = -1;
  logic [7:0] j_val = '0;

  task automatic job(input int n, input logic [7:0] v);
    j_n = n; j_val = v;
  endtask

  task automatic add(input string nm, input int cnt, input logic [6:0] in7,
                     input logic [7:0] msg, input logic [6:0] est,
                     input logic [7:0] ed, input logic [7:0] em, input logic epq);
    vec_t v;
    v.nm = nm; v.in7 = in7; v.msg = msg; v.mn = j_n; v.mv = j_val;
    v.est = est; v.ed = ed; v.em = em; v.epq = epq;
    for (int k = 0; k < cnt; k++) tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end else
      $display("ok   %s: %h", nm, act);
  endtask

  task automatic run_job(input string nm, input logic reuse, input int n,
                         input logic [7:0] v, input int exp_lat, input logic e_err,
                         input logic [7:0] e_data);
    int lat;
    req_valid_i = 1'b1; req_enc_i = 1'b1; req_key_reuse_i = reuse;
    req_msg_i = 16'h0010; mdl_n = n; mdl_val = v;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_result"}, {55'd0, resp_err_o, resp_data_o[7:0]}, {55'd0, e_err, e_data});
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check({nm, "_ack"}, {62'd0, resp_valid_o, req_ready_o}, 64'b01);
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_enc_i = 1'b0; req_key_reuse_i = 1'b0;
    req_p_i = 8'd11; req_q_i = 8'd13; req_msg_i = '0; abort_i = 1'b0;
    resp_ready_i = 1'b0;

    add("reset", 1, 7'b0000000, 8'h00, 7'b1000000, 8'h00, 8'h00, 1'b0);
    add("idle",  2, 7'b1000000, 8'h00, 7'b1000000, 8'h00, 8'h00, 1'b0);
    // Fresh-key encrypt
    job(5, 8'h5A);
    add("t1_accept", 1, 7'b1110000, 8'h2A, 7'b0100100, 8'h00, 8'h2A, 1'b1);
    add("t1_load",   1, 7'b1000000, 8'h00, 7'b0100100, 8'h00, 8'h2A, 1'b1);
    add("t1_keygen", 4, 7'b1000000, 8'h00, 7'b0110100, 8'h00, 8'h2A, 1'b1);
    add("t1_setup",  2, 7'b1000000, 8'h00, 7'b0110100, 8'h00, 8'h2A, 1'b1);
    add("t1_exp",    6, 7'b1000000, 8'h00, 7'b0111100, 8'h00, 8'h2A, 1'b1);
    add("t1_done",   2, 7'b1000000, 8'h00, 7'b0110110, 8'h5A, 8'h2A, 1'b1);
    add("t1_ack",    1, 7'b1000010, 8'h00, 7'b1010100, 8'h5A, 8'h2A, 1'b1);
    // Key reuse decrypt, then a long back-pressured response
    job(3, 8'h2A);
    add("t2_accept", 1, 7'b1101000, 8'h5A, 7'b0110000, 8'h5A, 8'h5A, 1'b1);
    add("t2_setup",  1, 7'b1000000, 8'h00, 7'b0110000, 8'h5A, 8'h5A, 1'b1);
    add("t2_exp",    4, 7'b1000000, 8'h00, 7'b0111000, 8'h5A, 8'h5A, 1'b1);
    add("t2_done",   1, 7'b1000000, 8'h00, 7'b0110010, 8'h2A, 8'h5A, 1'b1);
    add("t4_hold_abort_req", 5, 7'b1100100, 8'hFF, 7'b0110010, 8'h2A, 8'h5A, 1'b1);
    add("t4_hold",   5, 7'b1000000, 8'h00, 7'b0110010, 8'h2A, 8'h5A, 1'b1);
    add("t4_ack",    1, 7'b1000010, 8'h00, 7'b1010000, 8'h2A, 8'h5A, 1'b1);
    // Timeout: core never finishes
    job(-1, 8'hEE);
    add("t3_accept", 1, 7'b1111000, 8'h33, 7'b0110100, 8'h2A, 8'h33, 1'b1);
    add("t3_setup",  1, 7'b1000000, 8'h00, 7'b0110100, 8'h2A, 8'h33, 1'b1);
    add("t3_exp",   16, 7'b1000000, 8'h00, 7'b0111100, 8'h2A, 8'h33, 1'b1);
    add("t3_done",   1, 7'b1000000, 8'h00, 7'b0110111, 8'h00, 8'h33, 1'b1);
    add("t3_ack",    1, 7'b1000010, 8'h00, 7'b1010101, 8'h00, 8'h33, 1'b1);
    // Abort during key generation invalidates keys
    job(2, 8'h77);
    add("t5_accept", 1, 7'b1110000, 8'h44, 7'b0100101, 8'h00, 8'h44, 1'b1);
    add("t5_load",   1, 7'b1000000, 8'h00, 7'b0100101, 8'h00, 8'h44, 1'b1);
    add("t5_keygen", 2, 7'b1000000, 8'h00, 7'b0110101, 8'h00, 8'h44, 1'b1);
    add("t5_abort",  1, 7'b1000100, 8'h00, 7'b1010101, 8'h00, 8'h44, 1'b1);
    add("t5_reuse_req", 1, 7'b1101000, 8'h55, 7'b0100001, 8'h00, 8'h55, 1'b1);
    add("t5_load2",  1, 7'b1000000, 8'h00, 7'b0100001, 8'h00, 8'h55, 1'b1);
    add("t5_keygen2",4, 7'b1000000, 8'h00, 7'b0110001, 8'h00, 8'h55, 1'b1);
    add("t5_setup",  2, 7'b1000000, 8'h00, 7'b0110001, 8'h00, 8'h55, 1'b1);
    add("t5_exp",    3, 7'b1000000, 8'h00, 7'b0111001, 8'h00, 8'h55, 1'b1);
    add("t5_done",   1, 7'b1000000, 8'h00, 7'b0110010, 8'h77, 8'h55, 1'b1);
    add("t5_ack",    1, 7'b1000010, 8'h00, 7'b1010000, 8'h77, 8'h55, 1'b1);
    // Reset during EXP; a late finish must not produce a response
    job(4, 8'h99);
    add("t6_accept", 1, 7'b1111000, 8'h66, 7'b0110100, 8'h77, 8'h66, 1'b1);
    add("t6_setup",  1, 7'b1000000, 8'h00, 7'b0110100, 8'h77, 8'h66, 1'b1);
    add("t6_exp",    2, 7'b1000000, 8'h00, 7'b0111100, 8'h77, 8'h66, 1'b1);
    add("t6_reset",  1, 7'b0000000, 8'h00, 7'b1000000, 8'h00, 8'h00, 1'b0);
    add("t6_late_finish", 6, 7'b1000001, 8'h00, 7'b1000000, 8'h00, 8'h00, 1'b0);

    foreach (tbl[i]) begin
      {rst_n, req_valid_i, req_enc_i, req_key_reuse_i, abort_i, resp_ready_i, fin_force} = tbl[i].in7;
      req_msg_i = {8'h00, tbl[i].msg};
      mdl_n     = tbl[i].mn;
      mdl_val   = tbl[i].mv;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tbl[i].nm, i),
            {25'd0, req_ready_o, busy_o, core_rst_n_o, core_rst1_n_o, core_enc_o,
             resp_valid_o, resp_err_o, resp_data_o, core_msg_o, core_p_o, core_q_o},
            {25'd0, tbl[i].est, 8'h00, tbl[i].ed, 8'h00, tbl[i].em,
             (tbl[i].epq ? 8'd11 : 8'd0), (tbl[i].epq ? 8'd13 : 8'd0)});
    end

    // Keys invalid after reset: full path, finish on first EXP cycle
    rst_n = 1'b1; abort_i = 1'b0; fin_force = 1'b0; resp_ready_i = 1'b0;
    run_job("fresh_n0", 1'b1, 0, 8'hC3, 9, 1'b0, 8'hC3);
    // Finish on the timeout cycle: finish wins
    run_job("finish_at_timeout", 1'b1, 15, 8'h3C, 18, 1'b0, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_seq_ctrl.md
Name: rsa_seq_ctrl

Overview:
- Sequencing controller in front of the RSA core (inverter plus mod_exp behind a registered operand stage).
- Accepts one encrypt or decrypt job at a time over a valid/ready request channel.
- Drives the core's two active-low resets, its mode select and its operands in the correct order, then waits for the mod_exp finish flag with a timeout.
- Returns the result over a valid/ready response channel; can skip key regeneration when p/q are unchanged.

Parameters:
- WIDTH, 1024, prime width; message, modulus and result are 2*WIDTH.
- KEY_WAIT, 4096, cycles the inverter runs after its reset is released before keys are treated as stable.
- TIMEOUT, 1048576, maximum EXP cycles before the job is aborted with an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid_i  in  1  job request
- req_ready_o  out  1  controller can accept a job
- req_enc_i  in  1  1 = encrypt, 0 = decrypt
- req_key_reuse_i  in  1  skip key generation if keys are valid
- req_p_i, req_q_i  in  WIDTH each  primes
- req_msg_i  in  2*WIDTH  message or cipher
- abort_i  in  1  cancel the current job
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  result consumed
- resp_data_o  out  2*WIDTH  result
- resp_err_o  out  1  job timed out
- busy_o  out  1  state != IDLE
- core_rst_n_o  out  1  inverter reset to core
- core_rst1_n_o  out  1  mod_exp reset to core
- core_enc_o  out  1  core mode select
- core_p_o, core_q_o  out  WIDTH each  core primes
- core_msg_o  out  2*WIDTH  core message
- core_finish_i  in  1  mod_exp finish from core
- core_msg_i  in  2*WIDTH  core result

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready_o=1.
  - resp_valid_o=0, resp_err_o=0, resp_data_o=0, busy_o=0.
  - core_rst_n_o=0, core_rst1_n_o=0, core_enc_o=0.
  - core operands 0.
  - key_valid=0, counters 0.
- Operand registers:
  - p, q, msg and enc are latched on request acceptance (req_valid_i & req_ready_o).
  - core_* operands are driven from these registers and are stable for the whole job.
- req_ready_o is 1 only in IDLE.
- States:
  - IDLE:
    - On acceptance with req_key_reuse_i=1 and key_valid=1: go to SETUP.
    - Otherwise on acceptance: clear key_valid and go to LOAD.
  - LOAD: exactly 2 cycles, core_rst_n_o=0 and core_rst1_n_o=0, then KEYGEN.
  - KEYGEN: core_rst_n_o=1; count KEY_WAIT cycles; on the last cycle set key_valid=1 and go to SETUP.
  - SETUP: exactly 2 cycles with core_rst1_n_o=0. This covers the core's one-cycle operand register stage. Then EXP with the counter cleared.
  - EXP:
    - core_rst1_n_o=1.
    - On the first cycle core_finish_i=1: capture core_msg_i into resp_data_o, resp_err_o=0, go to DONE.
    - If instead the counter reaches TIMEOUT-1: resp_data_o=0, resp_err_o=1, go to DONE.
    - Finish and timeout in the same cycle: finish wins.
  - DONE:
    - resp_valid_o=1; data and err are held stable until resp_ready_i=1.
    - The handshake cycle returns to IDLE with resp_valid_o=0 on the next cycle.
- Reset levels by state:
  - core_rst1_n_o=0 in every state except EXP.
  - core_rst_n_o=1 once KEYGEN is entered, until the next LOAD or rst_n.
- Mode select: core_enc_o follows the latched enc in all non-IDLE states and holds its value in IDLE.
- core_finish_i is ignored outside EXP.
- abort_i in LOAD, KEYGEN, SETUP or EXP:
  - Next state IDLE, no response generated.
  - Abort in LOAD or KEYGEN leaves key_valid=0.
  - Abort in SETUP or EXP keeps key_valid.
  - abort_i is ignored in IDLE and DONE; a pending response is never dropped.
- rst_n low mid-job: all state returns to reset values on the next edge; any in-flight result is lost.
- Counters are sized clog2(max(KEY_WAIT,TIMEOUT)+1) and never wrap; both are cleared on every state entry.
- Latency from acceptance edge, fresh key: 2 + KEY_WAIT + 2 + N + 1 cycles to resp_valid_o, where N is the EXP cycle on which finish is seen, counting from 0.

Test Plan:
All scenarios use WIDTH=8, KEY_WAIT=4, TIMEOUT=16. The core model asserts finish N cycles after rst1 release and returns a fixed value.
1. Encrypt, p=11, q=13, msg=0x2A, model N=5 returning 0x5A -> exact sequence:
   - 2 cycles both resets low;
   - 4 cycles rst high / rst1 low;
   - 2 cycles rst1 low;
   - EXP;
   - resp_valid_o=1 with resp_data_o=0x5A, resp_err_o=0, core_enc_o=1.
2. Second job req_key_reuse_i=1, decrypt, msg=0x5A, N=3 returning 0x2A -> no LOAD or KEYGEN, core_rst_n_o stays 1, core_enc_o=0, response 0x2A after 2+3+1 cycles.
3. Model never finishes -> after 16 EXP cycles resp_valid_o=1, resp_err_o=1, resp_data_o=0; core_rst1_n_o=0 in DONE.
4. resp_ready_i held 0 for 10 cycles in DONE with abort_i and req_valid_i pulsed -> response held stable, req_ready_o=0, no state change; completes on the first ready cycle.
5. abort_i in KEYGEN cycle 2, then request with reuse=1 -> IDLE, then full LOAD/KEYGEN path taken because key_valid=0.
6. rst_n low for one cycle during EXP -> all outputs at reset values next cycle; late core_finish_i produces no response.
